// File: rtl/ucsbece154_sdram_ctrl_if.sv
// rtl/ucsbece154_sdram_ctrl_if.sv - refill and preload bus between the I-cache side and the SDRAM model
interface ucsbece154_sdram_ctrl_if;
  logic        MemReadRequest;
  logic [31:0] MemReadAddress;
  logic [31:0] MemDataIn;
  logic        MemDataReady;
  logic        MemBusy;
  logic        PreloadEnable;
  logic [31:0] PreloadAddress;
  logic [31:0] PreloadData;

  modport master (
    output MemReadRequest, MemReadAddress, PreloadEnable, PreloadAddress, PreloadData,
    input  MemDataIn, MemDataReady, MemBusy
  );

  modport slave (
    input  MemReadRequest, MemReadAddress, PreloadEnable, PreloadAddress, PreloadData,
    output MemDataIn, MemDataReady, MemBusy
  );
endinterface

// File: rtl/ucsbece154_sdram_ctrl.sv
// rtl/ucsbece154_sdram_ctrl.sv - behavioural SDRAM refill controller with fixed first-access latency
// Streams BLOCK_WORDS ascending words per request; backdoor preload port writes only while idle.
module ucsbece154_sdram_ctrl #(
  parameter int BLOCK_WORDS   = 4,
  parameter int FIRST_LATENCY = 10,
  parameter int WORD_GAP      = 0,
  parameter int MEM_WORDS     = 16384
) (
  input logic                     Clk,
  input logic                     Reset,
  ucsbece154_sdram_ctrl_if.slave  bus
);

  localparam int MEM_AW  = $clog2(MEM_WORDS);
  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int CNT_MAX = (FIRST_LATENCY > WORD_GAP) ? FIRST_LATENCY : WORD_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LATENCY = 3'd1;
  localparam logic [2:0] BURST   = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(FIRST_LATENCY - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WORD_GAP - 1);
  localparam logic [OFF_W-1:0] LAST_K   = OFF_W'(BLOCK_WORDS - 1);

  logic [31:0]              mem [MEM_WORDS];
  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OFF_W-1:0]         k_q, k_d;
  logic [MEM_AW-OFF_W-1:0]  base_q, base_d;
  logic [31:0]              data_q;
  logic                     ready_q;
  logic                     busy_q;
  logic [MEM_AW-1:0]        rd_idx;
  logic [MEM_AW-1:0]        wr_idx;
  logic                     req;
  logic                     unused_addr_bits;

  assign req    = bus.MemReadRequest;
  assign rd_idx = {base_q, k_d};
  assign wr_idx = bus.PreloadAddress[MEM_AW+1:2];

  assign unused_addr_bits = ^{bus.MemReadAddress[31:MEM_AW+2], bus.MemReadAddress[OFF_W+1:0],
                              bus.PreloadAddress[31:MEM_AW+2], bus.PreloadAddress[1:0]};

  // Any non-IDLE state with the request dropped aborts the refill.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          base_d  = bus.MemReadAddress[MEM_AW+1:OFF_W+2];
          k_d     = '0;
          cnt_d   = LAT_LOAD;
          state_d = LATENCY;
        end
      end
      LATENCY: begin
        if (!req)             state_d = IDLE;
        else if (cnt_q == '0) state_d = BURST;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      BURST: begin
        if (!req) begin
          state_d = IDLE;
        end else if (k_q == LAST_K) begin
          state_d = RELEASE;
        end else begin
          k_d = k_q + 1'b1;
          if (WORD_GAP > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (!req)             state_d = IDLE;
        else if (cnt_q == '0) state_d = BURST;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      RELEASE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state, so MemDataReady rises exactly with BURST.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      base_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      base_q  <= base_d;
      ready_q <= (state_d == BURST);
      busy_q  <= (state_d != IDLE);
      if (state_d == BURST) data_q <= mem[rd_idx];
    end
  end

  // Backing store is never cleared; preload is accepted only while idle.
  always_ff @(posedge Clk) begin
    if (!Reset && state_q == IDLE && bus.PreloadEnable) begin
      mem[wr_idx] <= bus.PreloadData;
    end
  end

  assign bus.MemDataIn    = data_q;
  assign bus.MemDataReady = ready_q;
  assign bus.MemBusy      = busy_q;

endmodule

// File: tb/tb_ucsbece154_sdram_ctrl.sv
// tb/tb_ucsbece154_sdram_ctrl.sv - scoreboard bench for the SDRAM refill controller
module tb_ucsbece154_sdram_ctrl;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  logic Clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 Clk = ~Clk;

  ucsbece154_sdram_ctrl_if ia ();
  ucsbece154_sdram_ctrl_if ib ();

  ucsbece154_sdram_ctrl #(
    .BLOCK_WORDS(4), .FIRST_LATENCY(10), .WORD_GAP(0), .MEM_WORDS(16384)
  ) dut_a (
    .Clk(Clk), .Reset(rst_a), .bus(ia.slave)
  );

  ucsbece154_sdram_ctrl #(
    .BLOCK_WORDS(4), .FIRST_LATENCY(10), .WORD_GAP(2), .MEM_WORDS(16384)
  ) dut_b (
    .Clk(Clk), .Reset(rst_b), .bus(ib.slave)
  );

  exp_t        qa[$];
  exp_t        qb[$];
  int          tests  = 0;
  int          fails  = 0;
  int          edge_n = 0;
  int          n;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge and matched against the scoreboards.
  task automatic step();
    exp_t e;
    @(posedge Clk);
    edge_n++;
    #1;
    if (ia.MemDataReady === 1'b1) begin
      tests++;
      assert (qa.size() > 0) else begin
        fails++;
        $error("FAIL a_extra_pulse: observed pulse at edge %0d data %h expected none", edge_n, ia.MemDataIn);
      end
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_data", ia.MemDataIn, e.data);
        check("a_edge", edge_n, e.at);
        last_a = e.data;
      end
    end else begin
      check("a_hold", ia.MemDataIn, last_a);
    end
    if (ib.MemDataReady === 1'b1) begin
      tests++;
      assert (qb.size() > 0) else begin
        fails++;
        $error("FAIL b_extra_pulse: observed pulse at edge %0d data %h expected none", edge_n, ib.MemDataIn);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_data", ib.MemDataIn, e.data);
        check("b_edge", edge_n, e.at);
        last_b = e.data;
      end
    end else begin
      check("b_hold", ib.MemDataIn, last_b);
    end
  endtask

  task automatic preload(input logic [31:0] baddr, input logic [31:0] data);
    ia.PreloadEnable = 1'b1; ia.PreloadAddress = baddr; ia.PreloadData = data;
    ib.PreloadEnable = 1'b1; ib.PreloadAddress = baddr; ib.PreloadData = data;
    step();
    ia.PreloadEnable = 1'b0;
    ib.PreloadEnable = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] d0, input int first_edge, input int count);
    for (int k = 0; k < count; k++) qa.push_back('{data: d0 + 32'(k), at: first_edge + k});
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ia.MemReadRequest = 1'b0; ia.MemReadAddress = '0;
    ia.PreloadEnable = 1'b0; ia.PreloadAddress = '0; ia.PreloadData = '0;
    ib.MemReadRequest = 1'b0; ib.MemReadAddress = '0;
    ib.PreloadEnable = 1'b0; ib.PreloadAddress = '0; ib.PreloadData = '0;
    step();
    step();
    check("reset_a_ready", ia.MemDataReady, 1'b0);
    check("reset_a_data", ia.MemDataIn, 32'h0);
    check("reset_a_busy", ia.MemBusy, 1'b0);
    check("reset_b_busy", ib.MemBusy, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int k = 0; k < 4; k++) begin
      preload(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      preload(32'h000 + 32'(4 * k), 32'hB0 + 32'(k));
      preload(32'h110 + 32'(4 * k), 32'hC4 + 32'(k));
    end

    // Back-to-back (A) and gapped (B) bursts from the same request; A held long after its last word.
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h104;
    ib.MemReadRequest = 1'b1; ib.MemReadAddress = 32'h104;
    n = edge_n + 1;
    push_a(32'hA0, n + 10, 4);
    for (int k = 0; k < 4; k++) qb.push_back('{data: 32'hA0 + 32'(k), at: n + 10 + 3 * k});
    step();
    check("a_busy_accept", ia.MemBusy, 1'b1);
    check("b_busy_accept", ib.MemBusy, 1'b1);
    repeat (28) step();
    check("a_burst_drained", 32'(qa.size()), 32'd0);
    check("b_burst_drained", 32'(qb.size()), 32'd0);
    check("a_busy_release", ia.MemBusy, 1'b1);
    ia.MemReadRequest = 1'b0;
    ib.MemReadRequest = 1'b0;
    step();
    check("a_busy_idle", ia.MemBusy, 1'b0);
    check("b_busy_idle", ib.MemBusy, 1'b0);

    // Re-raise, then abort after the second word.
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h104;
    n = edge_n + 1;
    push_a(32'hA0, n + 10, 2);
    for (int i = 0; i < 20 && qa.size() > 0; i++) step();
    check("a_abort_two_words", 32'(qa.size()), 32'd0);
    ia.MemReadRequest = 1'b0;
    step();
    check("a_abort_ready", ia.MemDataReady, 1'b0);
    check("a_abort_busy", ia.MemBusy, 1'b0);

    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h0;
    n = edge_n + 1;
    push_a(32'hB0, n + 10, 4);
    repeat (15) step();
    check("a_after_abort_drained", 32'(qa.size()), 32'd0);
    ia.MemReadRequest = 1'b0;
    step();

    // Preload on the same edge as the request lands before the burst reads it.
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h118;
    ia.PreloadEnable = 1'b1; ia.PreloadAddress = 32'h114; ia.PreloadData = 32'h1234_5678;
    n = edge_n + 1;
    qa.push_back('{data: 32'hC4, at: n + 10});
    qa.push_back('{data: 32'h1234_5678, at: n + 11});
    qa.push_back('{data: 32'hC6, at: n + 12});
    qa.push_back('{data: 32'hC7, at: n + 13});
    step();
    ia.PreloadEnable = 1'b0;
    repeat (14) step();
    check("a_same_edge_preload_drained", 32'(qa.size()), 32'd0);
    ia.MemReadRequest = 1'b0;
    step();

    // Reset during LATENCY.
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h104;
    repeat (3) step();
    check("a_busy_latency", ia.MemBusy, 1'b1);
    rst_a = 1'b1;
    last_a = '0;
    step();
    check("a_midreset_ready", ia.MemDataReady, 1'b0);
    check("a_midreset_data", ia.MemDataIn, 32'h0);
    check("a_midreset_busy", ia.MemBusy, 1'b0);
    rst_a = 1'b0;
    ia.MemReadRequest = 1'b0;
    repeat (12) step();
    check("a_post_reset_idle", ia.MemBusy, 1'b0);
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h104;
    n = edge_n + 1;
    push_a(32'hA0, n + 10, 4);
    repeat (15) step();
    check("a_mem_survives_reset", 32'(qa.size()), 32'd0);
    ia.MemReadRequest = 1'b0;
    step();

    // Address wrap, with a preload attempted while busy.
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h0001_0000;
    n = edge_n + 1;
    push_a(32'hB0, n + 10, 4);
    repeat (10) step();
    ia.PreloadEnable = 1'b1; ia.PreloadAddress = 32'h0000_000C; ia.PreloadData = 32'hDEAD_BEEF;
    repeat (5) step();
    ia.PreloadEnable = 1'b0;
    check("a_wrap_drained", 32'(qa.size()), 32'd0);
    ia.MemReadRequest = 1'b0;
    step();
    ia.MemReadRequest = 1'b1; ia.MemReadAddress = 32'h0;
    n = edge_n + 1;
    push_a(32'hB0, n + 10, 4);
    repeat (15) step();
    check("a_busy_preload_dropped", 32'(qa.size()), 32'd0);
    ia.MemReadRequest = 1'b0;
    step();
    check("b_never_extra", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
